uart_tx: RTL and testbench

Serial UART transmitter, the outbound counterpart of the existing `UART` receiver on `RsRx`. The core or test logic pushes bytes through a valid/ready port into an internal FIFO. The block serialises them as 8N1 frames on the `RsTx` pin at the same bit rate the receiver expects. It is driven from `clk` (100 MHz board clock) and is intended to hang off `OutputMap` as a write-only byte port.

---
 rtl/uart_pkg.sv | 15 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive pair.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;
  // Receiver and transmitter both use this so their bit rates stay matched.
  localparam int UART_DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO on distributed RAM; head byte is registered on pop and valid the
// following cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array: no reset, contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= 8'h00;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front; frames are sent back to back
// while bytes are queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           busy,
  output logic                           tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

  uart_tx_state_t state, state_next;
  logic [TW-1:0]  bit_timer, timer_next;
  logic [IW-1:0]  bit_idx, idx_next;
  logic [7:0]     shift, shift_next;
  logic           tx_next;
  logic           pop;
  logic           push;
  logic           full;
  logic           empty;
  logic           bit_end;
  logic [7:0]     fifo_data;

  assign data_ready = ~full;
  assign push       = data_valid & data_ready;
  assign busy       = (state != IDLE);
  assign bit_end    = (bit_timer == TIMER_MAX);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // State, timing and line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift     <= 8'h00;
      tx        <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      bit_timer <= timer_next;
      bit_idx   <= idx_next;
      shift     <= shift_next;
      tx        <= tx_next;
      overflow  <= data_valid & ~data_ready;
    end
  end

  // Next-state logic; the popped byte is loaded into shift as START ends,
  // once the FIFO's registered head has caught up.
  always_comb begin
    state_next = state;
    timer_next = bit_timer;
    idx_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;

    if (state == IDLE) begin
      timer_next = '0;
    end else if (bit_end) begin
      timer_next = '0;
    end else begin
      timer_next = bit_timer + TW'(1);
    end

    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end else begin
          tx_next = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          shift_next = fifo_data;
          tx_next    = fifo_data[0];
          idx_next   = '0;
        end else begin
          tx_next = 1'b0;
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
            idx_next   = bit_idx + IW'(1);
          end
        end else begin
          idx_next = bit_idx;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          tx_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed tables/sequences plus random
// traffic compared against a queue-and-frame-position reference model.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          data_ready;
  logic          overflow;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          tx;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .busy       (busy),
    .tx         (tx)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queued bytes, byte on the wire, cycles left in its frame.
  logic [7:0] mq[$];
  int         frame_left = 0;
  logic [7:0] cur = 8'h00;
  logic       m_ovf = 1'b0;

  function automatic void model_edge(input logic r, input logic v, input logic [7:0] d);
    bit full_pre;
    if (r) begin
      mq.delete();
      frame_left = 0;
      m_ovf = 1'b0;
    end else begin
      full_pre = (mq.size() >= DEPTH);
      m_ovf = v && full_pre;
      if (frame_left > 0) frame_left--;
      if (frame_left == 0 && mq.size() > 0) begin
        cur = mq.pop_front();
        frame_left = 10 * CPB;
      end
      if (v && !full_pre) mq.push_back(d);
    end
  endfunction

  function automatic logic exp_tx();
    int pos, b;
    if (frame_left == 0) return 1'b1;
    pos = 10 * CPB - frame_left;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r;
    data_valid = v;
    data_in = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(frame_left > 0));
    chk("data_ready", 32'(data_ready), 32'(mq.size() < DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_tx;
    logic       e_busy;
    logic       e_ready;
    logic       e_ovf;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[8];
  logic [9:0] frame_bits;

  initial begin
    // Full/overflow: 0x01..0x06 pushed back to back, 0x06 must be dropped.
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1};
    tbl[2] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    tbl[3] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    tbl[4] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
    tbl[5] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4};
    tbl[6] = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk("tbl_tx", 32'(tx), 32'(tbl[i].e_tx));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("tbl_ready", 32'(data_ready), 32'(tbl[i].e_ready));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].e_ovf));
      chk("tbl_count", 32'(fifo_count), 32'(tbl[i].e_cnt));
    end
    for (int i = 0; i < 5 * 10 * CPB; i++) step(1'b0, 1'b0, 8'h00);
    chk("ovf_drain_busy", 32'(busy), 32'd0);

    // Single byte 0xA5: start, LSB-first data, stop, each CPB cycles.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    chk("single_count", 32'(fifo_count), 32'd1);
    frame_bits = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("single_tx", 32'(tx), 32'(frame_bits[i / CPB]));
      chk("single_busy", 32'(busy), 32'd1);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("single_end_tx", 32'(tx), 32'd1);
    chk("single_end_busy", 32'(busy), 32'd0);

    // Back-to-back 0x00, 0xFF: no idle gap between frames.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("b2b_count0", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b1, 8'hFF);
    chk("b2b_count1", 32'(fifo_count), 32'd1);
    for (int i = 1; i <= 20 * CPB; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (i == 10 * CPB) begin
        chk("b2b_gap_tx", 32'(tx), 32'd0);
        chk("b2b_count2", 32'(fifo_count), 32'd0);
      end
      if (i == 20 * CPB) chk("b2b_end_busy", 32'(busy), 32'd0);
    end

    // Push on the STOP->START edge with two bytes queued.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    chk("pp_count_pre", 32'(fifo_count), 32'd2);
    for (int i = 0; i < 10 * CPB - 2; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h44);
    chk("pp_count", 32'(fifo_count), 32'd2);
    chk("pp_tx_start", 32'(tx), 32'd0);
    for (int i = 0; i < 3 * 10 * CPB + 2; i++) step(1'b0, 1'b0, 8'h00);
    chk("pp_drain_busy", 32'(busy), 32'd0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'h7E);
    for (int i = 0; i < 4 * CPB; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 15 * CPB; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("rst_quiet_tx", 32'(tx), 32'd1);
    end

    // Random traffic at three offered loads, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      int thresh;
      thresh = (i < 1000) ? 2 : ((i < 2000) ? 10 : 60);
      step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < thresh) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < (DEPTH + 1) * 10 * CPB; i++) step(1'b0, 1'b0, 8'h00);
    chk("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
